// File: rtl/rf_pkg.sv
// Shared defaults and helpers for the multi-port integer register file.
// Imported by reg_file_mp and rf_scoreboard.
package rf_pkg;

   localparam int unsigned XLEN_DEF  = 32;
   localparam int unsigned NREGS_DEF = 32;

   // Architectural index of the hardwired-zero register x0.
   localparam int unsigned ZERO_IDX  = 0;

   function automatic int unsigned rf_aw(input int unsigned nregs);
      return (nregs < 2) ? 1 : $clog2(nregs);
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy bits for hazard detection: a set marks a pending producer
// and a writeback clears it.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int unsigned NREGS    = NREGS_DEF,
   parameter int unsigned AW       = rf_aw(NREGS_DEF),
   parameter int unsigned ZERO_REG = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr_en,
   input  logic [AW-1:0]    clr_addr,
   input  logic             set_en,
   input  logic [AW-1:0]    set_addr,
   output logic [NREGS-1:0] busy_vec
);

   logic set_ok;

   always_comb begin
      set_ok = set_en;
      if ((ZERO_REG != 0) && (set_addr == AW'(ZERO_IDX))) begin
         set_ok = 1'b0;
      end
   end

   // The set is scheduled after the clear, so on a same-address collision the
   // newer producer wins and the bit stays busy.
   always_ff @(posedge clk) begin
      if (!rst) begin
         busy_vec <= '0;
      end else begin
         if (clr_en) begin
            busy_vec[clr_addr] <= 1'b0;
         end
         if (set_ok) begin
            busy_vec[set_addr] <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/reg_file_mp.sv
// Parametrised multi-read-port register file with optional write-to-read
// bypass, hardwired x0 and a busy scoreboard for pipeline hazard detection.
module reg_file_mp
   import rf_pkg::*;
#(
   parameter int unsigned XLEN     = XLEN_DEF,
   parameter int unsigned NREGS    = NREGS_DEF,
   parameter int unsigned NUM_RD   = 2,
   parameter int unsigned BYPASS   = 1,
   parameter int unsigned ZERO_REG = 1,
   localparam int unsigned AW      = rf_aw(NREGS)
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_RD*AW-1:0]   rd_addr,
   output logic [NUM_RD*XLEN-1:0] rd_data,
   output logic [NUM_RD-1:0]      rd_busy,
   input  logic                   we,
   input  logic [AW-1:0]          wa,
   input  logic [XLEN-1:0]        wd,
   input  logic                   busy_set,
   input  logic [AW-1:0]          busy_addr,
   output logic [NREGS-1:0]       busy_vec
);

   if ((NUM_RD < 1) || (NUM_RD > 4)) begin : g_bad_num_rd
      $error("reg_file_mp: NUM_RD must be 1..4");
   end
   if ((NREGS < 2) || ((NREGS & (NREGS - 1)) != 0)) begin : g_bad_nregs
      $error("reg_file_mp: NREGS must be a power of two >= 2");
   end

   logic [XLEN-1:0] regs [NREGS];
   logic            wr_ok;
   logic [AW-1:0]   a;
   logic            is_zero;
   logic            hit;

   always_comb begin
      wr_ok = we;
      if ((ZERO_REG != 0) && (wa == AW'(ZERO_IDX))) begin
         wr_ok = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned r = 0; r < NREGS; r++) begin
            regs[r] <= '0;
         end
      end else if (wr_ok) begin
         regs[wa] <= wd;
      end
   end

   rf_scoreboard #(
      .NREGS    (NREGS),
      .AW       (AW),
      .ZERO_REG (ZERO_REG)
   ) u_scoreboard (
      .clk      (clk),
      .rst      (rst),
      .clr_en   (we),
      .clr_addr (wa),
      .set_en   (busy_set),
      .set_addr (busy_addr),
      .busy_vec (busy_vec)
   );

   // Priority per port: reset, then x0, then bypass, then stored value.
   // A bypass hit means the producer is completing now, so busy is masked.
   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      a       = '0;
      is_zero = 1'b0;
      hit     = 1'b0;
      for (int unsigned i = 0; i < NUM_RD; i++) begin
         a       = rd_addr[i*AW +: AW];
         is_zero = (ZERO_REG != 0) && (a == AW'(ZERO_IDX));
         hit     = (BYPASS != 0) && we && (wa == a);
         if (rst && !is_zero) begin
            if (hit) begin
               rd_data[i*XLEN +: XLEN] = wd;
            end else begin
               rd_data[i*XLEN +: XLEN] = regs[a];
               rd_busy[i]              = busy_vec[a];
            end
         end
      end
   end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-read-port integer register file for the single-cycle and upcoming pipelined RISC-V cores.
- Generalises the current 2R/1W register file:
  - configurable data width, register count and read-port count;
  - hardwired-zero register x0;
  - optional same-cycle write-to-read bypass;
  - per-register busy scoreboard for pipeline hazard detection.
- Sits in decode; read data feeds the ALU operand muxes, the write port is driven from writeback.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, at least 2.
- NUM_RD, 2, number of independent read ports, 1 to 4.
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports; 0 = reads return the stored value only.
- ZERO_REG, 1, 1 = register 0 always reads 0 and ignores writes and busy-sets.
- AW, $clog2(NREGS), address width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous reset, active-low.
- rd_addr  in  NUM_RD*AW  packed read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NUM_RD*XLEN  packed read data, combinational.
- rd_busy  out  NUM_RD  per-port flag: the addressed register has an outstanding producer.
- we  in  1  write enable.
- wa  in  AW  write address.
- wd  in  XLEN  write data.
- busy_set  in  1  marks register busy_addr as pending (instruction issued).
- busy_addr  in  AW  destination of the issuing instruction.
- busy_vec  out  NREGS  full scoreboard, registered.

Behaviour:
- Reset:
  - At a posedge with rst=0, all registers are set to 0 and all busy bits are cleared.
  - While rst=0, rd_data is all-zero and rd_busy is 0, combinationally.
  - busy_vec reads 0 from the first edge with rst=0.
  - Reset asserted mid-operation discards any concurrent write or busy_set on that edge.
- Write:
  - At a posedge with rst=1 and we=1, regs[wa] takes wd.
  - With ZERO_REG=1 and wa=0, the write is dropped.
  - Write latency is 1 cycle: the stored value is visible on the next cycle's reads.
- Read:
  - Port i is purely combinational: rd_data_i = regs[rd_addr_i].
  - ZERO_REG=1 and rd_addr_i=0 gives 0 regardless of storage or bypass.
  - BYPASS=1 and we=1 and wa=rd_addr_i (address nonzero when ZERO_REG=1) gives rd_data_i = wd in the same cycle.
  - Every port bypasses independently; several ports may hit the same address.
- Scoreboard:
  - A posedge with rst=1 and we=1 clears busy[wa].
  - A posedge with rst=1 and busy_set=1 sets busy[busy_addr], except when ZERO_REG=1 and busy_addr=0.
  - If the clear and the set target the same address on the same edge, the set wins and the bit ends at 1 (a newer producer has issued).
  - Clears and sets on different addresses both take effect.
- Busy reporting:
  - rd_busy_i = busy[rd_addr_i], forced to 0 when BYPASS=1 and a bypass hit occurs on port i this cycle.
  - rd_busy_i is always 0 for x0 when ZERO_REG=1.
- Busy-clear rules:
  - A write to a register that is not busy is legal and leaves the bit at 0.
  - A second busy_set to an already busy register keeps the bit at 1; there is no count.
- Width: addresses are used unsigned and in range by construction; no wrap or out-of-range handling is required.

Decomposition:
- Shared package (rf_pkg):
  - XLEN_DEF = 32, NREGS_DEF = 32;
  - address-width function;
  - the register-index constant for x0.
- One natural sub-module, rf_scoreboard: holds the NREGS busy bits and the set/clear priority logic, exposing busy_vec.
- Storage, read muxing and bypass stay in reg_file_mp.

Test Plan:
- Reset: hold rst=0 for 2 cycles with we=1, wa=5, wd=0xDEADBEEF → rd_data=0 and busy_vec=0 throughout; after release, reading reg 5 returns 0.
- Write then read: write 0x00000020 to reg 9, next cycle read ports 0/1 at 9/9 → both return 0x00000020. Write 0x12345678 to reg 0 → reading 0 returns 0.
- Bypass: reg 6 holds 0x40; in one cycle we=1, wa=6, wd=0x99 with rd_addr0=6 → rd_data0=0x99 combinationally with BYPASS=1, and 0x40 with BYPASS=0; next cycle both configurations read 0x99.
- Scoreboard set/clear: busy_set on reg 3 → next cycle rd_busy for reg 3 is 1 and busy_vec[3]=1; write reg 3 → in that cycle rd_busy=0 with BYPASS=1; next cycle busy_vec[3]=0.
- Simultaneous set and clear: we=1, wa=7 and busy_set=1, busy_addr=7 on the same edge → busy_vec[7]=1. Same edge with wa=7, busy_addr=8 → bit 7 is 0 and bit 8 is 1.
- Parameter sweep: NUM_RD=4, NREGS=16, XLEN=64 → four ports read distinct registers with independent values; x0 busy_set is ignored.
